// File: rtl/taxi_qsfp_link_supervisor_if.sv
// Status/control bundle between the QSFP link supervisor, the cage sideband and the MAC quad.
// No valid/ready handshake here: every signal is a level, sampled or driven every clock.
interface taxi_qsfp_link_supervisor_if #(
    parameter int CNT    = 4,
    parameter int FLAP_W = 16
);
    logic                  modprs_l;
    logic [CNT-1:0]        rx_status;
    logic                  clr_flap;
    logic [CNT-1:0]        lane_rst;
    logic [CNT-1:0]        link_up;
    logic                  all_up;
    logic [CNT*FLAP_W-1:0] flap_count;
    logic                  led_g;
    logic                  led_r;

    modport master (
        input  modprs_l, rx_status, clr_flap,
        output lane_rst, link_up, all_up, flap_count, led_g, led_r
    );

    modport slave (
        output modprs_l, rx_status, clr_flap,
        input  lane_rst, link_up, all_up, flap_count, led_g, led_r
    );
endinterface

// File: rtl/taxi_qsfp_link_supervisor.sv
// Per-lane QSFP28 link bring-up sequencer: lane reset pulsing, lock timeout, link debounce, flap counting, LEDs.
// Optional retry limit with a FAILED state is enabled by defining TAXI_LINK_SUP_RETRY_LIMIT_EN.
module taxi_qsfp_link_supervisor #(
    parameter int CNT           = 4,
    parameter int TIMEOUT_CYC   = 2500000,
    parameter int RST_PULSE_CYC = 16,
    parameter int DEBOUNCE_CYC  = 1024,
    parameter int FLAP_W        = 16,
    parameter int MAX_RETRY     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    taxi_qsfp_link_supervisor_if.master bus,
    output logic [3*CNT-1:0]            dbg_state
);
    typedef enum logic [2:0] {
        ST_ABSENT = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UP     = 3'd3,
        ST_FAILED = 3'd4
    } state_e;

    localparam int MAX_A   = (TIMEOUT_CYC > RST_PULSE_CYC) ? TIMEOUT_CYC : RST_PULSE_CYC;
    localparam int MAX_CYC = (MAX_A > DEBOUNCE_CYC) ? MAX_A : DEBOUNCE_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] T_ONE        = TW'(1);
    localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] DEB_LAST     = TW'(DEBOUNCE_CYC - 1);

    logic [1:0]     prs_sync_q, prs_sync_d;
    logic [CNT-1:0] rx_meta_q, rx_meta_d;
    logic [CNT-1:0] rx_sync_q, rx_sync_d;
    logic           present;

    state_e            state_q [CNT];
    state_e            state_d [CNT];
    logic [TW-1:0]     timer_q [CNT];
    logic [TW-1:0]     timer_d [CNT];
    logic [TW-1:0]     deb_q   [CNT];
    logic [TW-1:0]     deb_d   [CNT];
    logic [FLAP_W-1:0] flap_q  [CNT];
    logic [FLAP_W-1:0] flap_d  [CNT];

    logic [CNT-1:0] lane_rst_q, lane_rst_d;
    logic [CNT-1:0] link_up_q, link_up_d;
    logic           all_up_q, all_up_d;
    logic           led_g_q, led_g_d;
    logic           led_r_q, led_r_d;

`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
    localparam int            RW         = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    logic [RW-1:0] retry_q [CNT];
    logic [RW-1:0] retry_d [CNT];
    logic [22:0]   blink_q, blink_d;
    logic          any_failed_d;
`else
    // MAX_RETRY only matters when the retry limit is built in.
    if (MAX_RETRY < 0) begin : g_no_retry_limit
    end
`endif

    // Synced modprs_l is active-low, so the reset value 1 reads as "absent".
    assign present = ~prs_sync_q[1];

    always_comb begin
        prs_sync_d = {prs_sync_q[0], bus.modprs_l};
        rx_meta_d  = bus.rx_status;
        rx_sync_d  = rx_meta_q;

        for (int i = 0; i < CNT; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            deb_d[i]   = deb_q[i];
            flap_d[i]  = flap_q[i];
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
            retry_d[i] = retry_q[i];
`endif
            case (state_q[i])
                ST_ABSENT: begin
                    if (present) begin
                        state_d[i] = ST_RESET;
                        timer_d[i] = '0;
                    end
                end
                ST_RESET: begin
                    if (timer_q[i] == PULSE_LAST) begin
                        state_d[i] = ST_WAIT;
                        timer_d[i] = '0;
                        deb_d[i]   = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + T_ONE;
                    end
                end
                ST_WAIT: begin
                    deb_d[i]   = rx_sync_q[i] ? (deb_q[i] + T_ONE) : '0;
                    timer_d[i] = timer_q[i] + T_ONE;
                    // Debounce completion is tested first so it wins a tie with the timeout.
                    if (rx_sync_q[i] && (deb_q[i] == DEB_LAST)) begin
                        state_d[i] = ST_UP;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                        retry_d[i] = '0;
`endif
                    end else if (timer_q[i] == TIMEOUT_LAST) begin
                        timer_d[i] = '0;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                        retry_d[i] = retry_q[i] + RW'(1);
                        state_d[i] = (retry_q[i] == RETRY_LAST) ? ST_FAILED : ST_RESET;
`else
                        state_d[i] = ST_RESET;
`endif
                    end
                end
                ST_UP: begin
                    if (!rx_sync_q[i]) begin
                        state_d[i] = ST_WAIT;
                        timer_d[i] = '0;
                        deb_d[i]   = '0;
                        if (flap_q[i] != {FLAP_W{1'b1}}) begin
                            flap_d[i] = flap_q[i] + FLAP_W'(1);
                        end
                    end
                end
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                ST_FAILED: begin
                    state_d[i] = ST_FAILED;
                end
`endif
                default: begin
                    state_d[i] = ST_ABSENT;
                end
            endcase

            // Module removal overrides every other transition.
            if (!present) begin
                state_d[i] = ST_ABSENT;
                timer_d[i] = '0;
                deb_d[i]   = '0;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                retry_d[i] = '0;
`endif
            end

            if (bus.clr_flap) begin
                flap_d[i] = '0;
            end

            lane_rst_d[i] = (state_d[i] != ST_WAIT) && (state_d[i] != ST_UP);
            link_up_d[i]  = (state_d[i] == ST_UP);
        end

        all_up_d = &link_up_d;
        led_g_d  = all_up_d;
        led_r_d  = present && !all_up_d;

`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
        any_failed_d = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            if (state_d[i] == ST_FAILED) begin
                any_failed_d = 1'b1;
            end
        end
        blink_d = blink_q + 23'd1;
        if (any_failed_d) begin
            led_r_d = blink_q[22];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_sync_q <= 2'b11;
            rx_meta_q  <= '0;
            rx_sync_q  <= '0;
            for (int i = 0; i < CNT; i++) begin
                state_q[i] <= ST_ABSENT;
                timer_q[i] <= '0;
                deb_q[i]   <= '0;
                flap_q[i]  <= '0;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                retry_q[i] <= '0;
`endif
            end
            lane_rst_q <= '1;
            link_up_q  <= '0;
            all_up_q   <= 1'b0;
            led_g_q    <= 1'b0;
            led_r_q    <= 1'b0;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
            blink_q    <= '0;
`endif
        end else begin
            prs_sync_q <= prs_sync_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            for (int i = 0; i < CNT; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                deb_q[i]   <= deb_d[i];
                flap_q[i]  <= flap_d[i];
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
                retry_q[i] <= retry_d[i];
`endif
            end
            lane_rst_q <= lane_rst_d;
            link_up_q  <= link_up_d;
            all_up_q   <= all_up_d;
            led_g_q    <= led_g_d;
            led_r_q    <= led_r_d;
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
            blink_q    <= blink_d;
`endif
        end
    end

    for (genvar g = 0; g < CNT; g++) begin : g_lane_out
        assign dbg_state[3*g +: 3]                = state_q[g];
        assign bus.flap_count[g*FLAP_W +: FLAP_W] = flap_q[g];
    end

    assign bus.lane_rst = lane_rst_q;
    assign bus.link_up  = link_up_q;
    assign bus.all_up   = all_up_q;
    assign bus.led_g    = led_g_q;
    assign bus.led_r    = led_r_q;
endmodule

// File: tb/tb_taxi_qsfp_link_supervisor.sv
// Directed bench for taxi_qsfp_link_supervisor with short timeouts; expected values are hand-derived cycle counts.
module tb_taxi_qsfp_link_supervisor;
    localparam int CNT           = 4;
    localparam int TIMEOUT_CYC   = 100;
    localparam int RST_PULSE_CYC = 8;
    localparam int DEBOUNCE_CYC  = 4;
    localparam int FLAP_W        = 4;
    localparam int MAX_RETRY     = 3;

    localparam logic [2:0] S_ABSENT = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UP     = 3'd3;
    localparam logic [2:0] S_FAILED = 3'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3*CNT-1:0] dbg_state;
    int               n_vec = 0;
    int               n_err = 0;

    taxi_qsfp_link_supervisor_if #(.CNT(CNT), .FLAP_W(FLAP_W)) bus ();

    taxi_qsfp_link_supervisor #(
        .CNT          (CNT),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .RST_PULSE_CYC(RST_PULSE_CYC),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .FLAP_W       (FLAP_W),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.modprs_l  = 1'b1;
        bus.rx_status = '0;
        bus.clr_flap  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Leaves all lanes UP 15 edges after modprs_l falls (2 sync + 1 + 8 pulse + 4 debounce).
    task automatic bring_up();
        apply_reset();
        bus.modprs_l  = 1'b0;
        bus.rx_status = 4'hF;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.modprs_l  = 1'b1;
        bus.rx_status = '0;
        bus.clr_flap  = 1'b0;
        repeat (2) tick();
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL rst_lane_rst: got %h want %h", bus.lane_rst, 4'hF); end
        n_vec++; if (bus.link_up !== 4'h0) begin n_err++; $display("FAIL rst_link_up: got %h want %h", bus.link_up, 4'h0); end
        n_vec++; if ({bus.all_up, bus.led_g, bus.led_r} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {bus.all_up, bus.led_g, bus.led_r}); end
        n_vec++; if (bus.flap_count !== 16'h0000) begin n_err++; $display("FAIL rst_flap: got %h want 0000", bus.flap_count); end
        n_vec++; if (dbg_state !== {4{S_ABSENT}}) begin n_err++; $display("FAIL rst_state: got %h want %h", dbg_state, {4{S_ABSENT}}); end
    endtask

    task automatic test_absent_idle();
        apply_reset();
        repeat (50) tick();
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL idle_lane_rst: got %h want %h", bus.lane_rst, 4'hF); end
        n_vec++; if (bus.link_up !== 4'h0) begin n_err++; $display("FAIL idle_link_up: got %h want 0", bus.link_up); end
        n_vec++; if (bus.led_r !== 1'b0) begin n_err++; $display("FAIL idle_led_r: got %b want 0", bus.led_r); end
        n_vec++; if (dbg_state !== {4{S_ABSENT}}) begin n_err++; $display("FAIL idle_state: got %h want %h", dbg_state, {4{S_ABSENT}}); end
    endtask

    task automatic test_bring_up();
        apply_reset();
        bus.modprs_l  = 1'b0;
        bus.rx_status = 4'hF;
        repeat (3) tick();
        n_vec++; if (dbg_state !== {4{S_RESET}}) begin n_err++; $display("FAIL up_state_reset: got %h want %h", dbg_state, {4{S_RESET}}); end
        repeat (7) tick();
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL up_pulse_end: got %h want F", bus.lane_rst); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL up_wait_lane_rst: got %h want 0", bus.lane_rst); end
        n_vec++; if (dbg_state !== {4{S_WAIT}}) begin n_err++; $display("FAIL up_state_wait: got %h want %h", dbg_state, {4{S_WAIT}}); end
        n_vec++; if (bus.led_r !== 1'b1) begin n_err++; $display("FAIL up_led_r_wait: got %b want 1", bus.led_r); end
        repeat (3) tick();
        n_vec++; if (bus.link_up !== 4'h0) begin n_err++; $display("FAIL up_early: got %h want 0", bus.link_up); end
        tick();
        n_vec++; if (bus.link_up !== 4'hF) begin n_err++; $display("FAIL up_link_up: got %h want F", bus.link_up); end
        n_vec++; if ({bus.all_up, bus.led_g, bus.led_r} !== 3'b110) begin n_err++; $display("FAIL up_flags: got %b want 110", {bus.all_up, bus.led_g, bus.led_r}); end
    endtask

    task automatic test_timeout_retry();
        apply_reset();
        bus.modprs_l  = 1'b0;
        bus.rx_status = 4'b1011;
        repeat (110) tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL to_before: got %h want 0", bus.lane_rst); end
        n_vec++; if (bus.link_up !== 4'b1011) begin n_err++; $display("FAIL to_link_up: got %h want b", bus.link_up); end
        n_vec++; if ({bus.all_up, bus.led_r} !== 2'b01) begin n_err++; $display("FAIL to_flags: got %b want 01", {bus.all_up, bus.led_r}); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'b0100) begin n_err++; $display("FAIL to_pulse1_start: got %h want 4", bus.lane_rst); end
        repeat (7) tick();
        n_vec++; if (bus.lane_rst !== 4'b0100) begin n_err++; $display("FAIL to_pulse1_last: got %h want 4", bus.lane_rst); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL to_pulse1_end: got %h want 0", bus.lane_rst); end
        repeat (99) tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL to_wait2_last: got %h want 0", bus.lane_rst); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'b0100) begin n_err++; $display("FAIL to_pulse2_start: got %h want 4", bus.lane_rst); end
        repeat (8) tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL to_pulse2_end: got %h want 0", bus.lane_rst); end
        repeat (100) tick();
        n_vec++; if (bus.lane_rst !== 4'b0100) begin n_err++; $display("FAIL to_third: got %h want 4", bus.lane_rst); end
`ifdef TAXI_LINK_SUP_RETRY_LIMIT_EN
        n_vec++; if (dbg_state[8:6] !== S_FAILED) begin n_err++; $display("FAIL to_failed_state: got %h want %h", dbg_state[8:6], S_FAILED); end
        repeat (8) tick();
        n_vec++; if (bus.lane_rst !== 4'b0100) begin n_err++; $display("FAIL to_failed_hold: got %h want 4", bus.lane_rst); end
        n_vec++; if (bus.led_r !== 1'b0) begin n_err++; $display("FAIL to_failed_blink: got %b want 0", bus.led_r); end
`else
        n_vec++; if (dbg_state[8:6] !== S_RESET) begin n_err++; $display("FAIL to_third_state: got %h want %h", dbg_state[8:6], S_RESET); end
        repeat (8) tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL to_retry_again: got %h want 0", bus.lane_rst); end
`endif
        n_vec++; if (bus.link_up !== 4'b1011) begin n_err++; $display("FAIL to_others_up: got %h want b", bus.link_up); end
    endtask

    task automatic test_flap_count();
        bring_up();
        for (int d = 1; d <= 17; d++) begin
            bus.rx_status[1] = 1'b0;
            tick();
            bus.rx_status[1] = 1'b1;
            repeat (9) tick();
            if (d == 1) begin
                n_vec++; if (bus.flap_count !== 16'h0010) begin n_err++; $display("FAIL flap_first: got %h want 0010", bus.flap_count); end
                n_vec++; if (bus.link_up !== 4'hF) begin n_err++; $display("FAIL flap_relock: got %h want F", bus.link_up); end
            end
            if (d == 14) begin
                n_vec++; if (bus.flap_count !== 16'h00E0) begin n_err++; $display("FAIL flap_14: got %h want 00e0", bus.flap_count); end
            end
        end
        n_vec++; if (bus.flap_count !== 16'h00F0) begin n_err++; $display("FAIL flap_sat: got %h want 00f0", bus.flap_count); end
        bus.rx_status[1] = 1'b0;
        tick();
        bus.rx_status[1] = 1'b1;
        tick();
        bus.clr_flap = 1'b1;
        tick();
        bus.clr_flap = 1'b0;
        n_vec++; if (bus.flap_count !== 16'h0000) begin n_err++; $display("FAIL flap_clr_wins: got %h want 0000", bus.flap_count); end
        n_vec++; if (dbg_state[5:3] !== S_WAIT) begin n_err++; $display("FAIL flap_clr_drop: got %h want %h", dbg_state[5:3], S_WAIT); end
        repeat (8) tick();
        n_vec++; if ({bus.link_up, bus.flap_count} !== {4'hF, 16'h0000}) begin n_err++; $display("FAIL flap_after_clr: got %h want f0000", {bus.link_up, bus.flap_count}); end
    endtask

    task automatic test_debounce_glitch();
        logic [7:0] pat;
        pat = 8'b1111_0111;
        apply_reset();
        bus.modprs_l  = 1'b0;
        bus.rx_status = 4'b1110;
        repeat (20) tick();
        n_vec++; if (dbg_state[2:0] !== S_WAIT) begin n_err++; $display("FAIL deb_wait: got %h want %h", dbg_state[2:0], S_WAIT); end
        for (int k = 0; k < 8; k++) begin
            bus.rx_status[0] = pat[k];
            tick();
            n_vec++; if (bus.link_up[0] !== 1'b0) begin n_err++; $display("FAIL deb_early_%0d: got %b want 0", k, bus.link_up[0]); end
        end
        tick();
        n_vec++; if (bus.link_up[0] !== 1'b0) begin n_err++; $display("FAIL deb_one_short: got %b want 0", bus.link_up[0]); end
        tick();
        n_vec++; if (bus.link_up !== 4'hF) begin n_err++; $display("FAIL deb_up: got %h want F", bus.link_up); end
    endtask

    task automatic test_removal();
        bring_up();
        bus.rx_status = 4'b0111;
        tick();
        bus.rx_status = 4'hF;
        repeat (9) tick();
        n_vec++; if (bus.flap_count !== 16'h1000) begin n_err++; $display("FAIL rm_flap_pre: got %h want 1000", bus.flap_count); end
        bus.modprs_l = 1'b1;
        repeat (2) tick();
        n_vec++; if (bus.link_up !== 4'hF) begin n_err++; $display("FAIL rm_sync_delay: got %h want F", bus.link_up); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL rm_lane_rst: got %h want F", bus.lane_rst); end
        n_vec++; if (dbg_state !== {4{S_ABSENT}}) begin n_err++; $display("FAIL rm_state: got %h want %h", dbg_state, {4{S_ABSENT}}); end
        n_vec++; if ({bus.link_up, bus.all_up, bus.led_g, bus.led_r} !== 7'd0) begin n_err++; $display("FAIL rm_outputs: got %b want 0", {bus.link_up, bus.all_up, bus.led_g, bus.led_r}); end
        n_vec++; if (bus.flap_count !== 16'h1000) begin n_err++; $display("FAIL rm_flap_kept: got %h want 1000", bus.flap_count); end
    endtask

    task automatic test_async_reset();
        bus.modprs_l  = 1'b0;
        bus.rx_status = 4'h0;
        repeat (5) tick();
        n_vec++; if (dbg_state !== {4{S_RESET}}) begin n_err++; $display("FAIL ar_in_reset: got %h want %h", dbg_state, {4{S_RESET}}); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL ar_lane_rst: got %h want F", bus.lane_rst); end
        n_vec++; if (dbg_state !== {4{S_ABSENT}}) begin n_err++; $display("FAIL ar_state: got %h want %h", dbg_state, {4{S_ABSENT}}); end
        n_vec++; if (bus.flap_count !== 16'h0000) begin n_err++; $display("FAIL ar_flap: got %h want 0000", bus.flap_count); end
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        n_vec++; if ({bus.lane_rst, dbg_state[2:0]} !== {4'hF, S_RESET}) begin n_err++; $display("FAIL ar_repulse: got %h want %h", {bus.lane_rst, dbg_state[2:0]}, {4'hF, S_RESET}); end
        tick();
        n_vec++; if (bus.lane_rst !== 4'h0) begin n_err++; $display("FAIL ar_wait: got %h want 0", bus.lane_rst); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.lane_rst !== 4'hF) begin n_err++; $display("FAIL ar_async_assert: got %h want F", bus.lane_rst); end
        n_vec++; if (dbg_state !== {4{S_ABSENT}}) begin n_err++; $display("FAIL ar_async_state: got %h want %h", dbg_state, {4{S_ABSENT}}); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_absent_idle();
        test_bring_up();
        test_timeout_retry();
        test_flap_count();
        test_debounce_glitch();
        test_removal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
